// File: rtl/prio_pkg.sv
// Shared types and helpers for the priority scan encoder.
// Holds the scan FSM state encoding and the code-width function.
package prio_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Smallest r such that 2**r >= v; used to size codes 0..N.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_enc_n.sv
// N-bit highest-set-bit encoder: bit i -> code i+1, empty vector -> code 0.
// Purely combinational; instantiated once per code the scanner reports.
module prio_enc_n #(
   parameter int N  = 12,
   parameter int CW = 4
) (
   input  logic [N-1:0]  vec,
   output logic [CW-1:0] code
);

   always_comb begin
      code = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            code = CW'(i + 1);
         end
      end
   end

endmodule

// File: rtl/priority_scan_encoder.sv
// Snapshots a request vector and streams its set bits highest-first,
// one code per handshake, with a lookahead second code and remaining count.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no snapshot held; outputs zero; start with req!=0 loads one
// SCAN  | snapshot non-empty; out_valid high until the final handshake
module priority_scan_encoder
   import prio_pkg::*;
#(
   parameter  int N  = 12,
   localparam int CW = clog2(N + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [N-1:0]  req,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] first,
   output logic [CW-1:0] second,
   output logic          last,
   output logic [CW-1:0] count,
   output logic          done
);

   state_t        state, state_next;
   logic [N-1:0]  snap, snap_next;
   logic [N-1:0]  top_oh;
   logic [N-1:0]  snap_rest;
   logic          done_q, done_next;
   logic [CW-1:0] first_c, second_c, count_c;
   logic          scanning;
   logic          final_beat;

   // One-hot of the highest set snapshot bit; cleared on each handshake.
   always_comb begin
      top_oh = '0;
      for (int i = 0; i < N; i++) begin
         if (snap[i]) begin
            top_oh    = '0;
            top_oh[i] = 1'b1;
         end
      end
   end

   assign snap_rest = snap & ~top_oh;

   always_comb begin
      count_c = '0;
      for (int i = 0; i < N; i++) begin
         count_c = count_c + CW'(snap[i]);
      end
   end

   prio_enc_n #(
      .N  (N),
      .CW (CW)
   ) u_enc_first (
      .vec  (snap),
      .code (first_c)
   );

   prio_enc_n #(
      .N  (N),
      .CW (CW)
   ) u_enc_second (
      .vec  (snap_rest),
      .code (second_c)
   );

   assign scanning   = (state == SCAN);
   assign final_beat = scanning && (count_c == CW'(1));

   always_comb begin
      state_next = state;
      snap_next  = snap;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (|req) begin
                  snap_next  = req;
                  state_next = SCAN;
               end else begin
                  done_next = 1'b1;
               end
            end
         end
         SCAN: begin
            // start is deliberately not looked at here, including on the final beat.
            if (out_ready) begin
               snap_next = snap_rest;
               if (final_beat) begin
                  snap_next  = '0;
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: begin
            snap_next  = '0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         snap   <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         snap   <= snap_next;
         done_q <= done_next;
      end
   end

   // Gate on state so IDLE outputs are zero independent of snapshot contents.
   assign busy      = scanning;
   assign out_valid = scanning;
   assign first     = scanning ? first_c  : '0;
   assign second    = scanning ? second_c : '0;
   assign count     = scanning ? count_c  : '0;
   assign last      = final_beat;
   assign done      = done_q;

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Self-checking bench for priority_scan_encoder (N=12) using a queue of
// expected beats filled by a reference model when each start is driven.
module tb_priority_scan_encoder;

   localparam int N  = 12;
   localparam int CW = 4;

   typedef struct packed {
      logic [CW-1:0] first;
      logic [CW-1:0] second;
      logic [CW-1:0] count;
      logic          last;
   } beat_t;

   logic          clk;
   logic          reset;
   logic          start;
   logic [N-1:0]  req;
   logic          busy;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] first;
   logic [CW-1:0] second;
   logic          last;
   logic [CW-1:0] count;
   logic          done;

   int    n_checks;
   int    n_pass;
   beat_t exp_q[$];

   priority_scan_encoder #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .req       (req),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .first     (first),
      .second    (second),
      .last      (last),
      .count     (count),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: walk the vector from the top, one beat per set bit.
   task automatic push_model(input logic [N-1:0] v);
      logic [N-1:0] rem;
      int h, s, pc;
      beat_t b;
      rem = v;
      while (rem != '0) begin
         h = -1; s = -1; pc = 0;
         for (int i = N - 1; i >= 0; i--) begin
            if (rem[i]) begin
               pc++;
               if (h < 0) h = i;
               else if (s < 0) s = i;
            end
         end
         b.first  = CW'(h + 1);
         b.second = (s < 0) ? '0 : CW'(s + 1);
         b.count  = CW'(pc);
         b.last   = (pc == 1);
         exp_q.push_back(b);
         rem[h] = 1'b0;
      end
   endtask

   // Leaves the caller at the first negedge after the load edge.
   task automatic do_start(input logic [N-1:0] v);
      @(negedge clk);
      start = 1'b1;
      req   = v;
      push_model(v);
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic beat_t obs_beat();
      beat_t o;
      o.first  = first;
      o.second = second;
      o.count  = count;
      o.last   = last;
      return o;
   endfunction

   task automatic test_reset();
      logic [15:0] obs;
      reset = 1'b1; start = 1'b1; req = 12'hFFF; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      obs = {busy, out_valid, done, first, second, count, last};
      n_checks++;
      if (obs !== 16'h0) $display("FAIL reset_outputs: got %h want 0000", obs);
      else n_pass++;
      reset = 1'b0; start = 1'b0; req = '0;
      @(negedge clk);
      obs = {busy, out_valid, done, first, second, count, last};
      n_checks++;
      if (obs !== 16'h0) $display("FAIL idle_outputs: got %h want 0000", obs);
      else n_pass++;
   endtask

   task automatic test_mixed();
      beat_t o, e;
      bit fin;
      fin = 0;
      out_ready = 1'b1;
      do_start(12'b1000_0010_0001);
      for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
         if (out_valid) begin
            o = obs_beat();
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL mixed_extra_beat: got %h want none", o);
            end else begin
               e = exp_q.pop_front();
               if (o !== e) $display("FAIL mixed_beat: got %h want %h", o, e);
               else n_pass++;
            end
            if (last) fin = 1;
         end
         @(negedge clk);
      end
      n_checks++;
      if (!fin || exp_q.size() != 0) begin
         $display("FAIL mixed_complete: finished %0d left %0d want 1 0", fin, exp_q.size());
         exp_q.delete();
      end else n_pass++;
      n_checks++;
      if ({done, busy} !== 2'b10) $display("FAIL mixed_done: got %b want 10", {done, busy});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) $display("FAIL mixed_done_width: got %b want 0", done);
      else n_pass++;
   endtask

   task automatic test_empty();
      out_ready = 1'b1;
      do_start(12'h000);
      n_checks++;
      if ({done, busy, out_valid} !== 3'b100)
         $display("FAIL empty_done: got %b want 100", {done, busy, out_valid});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({done, busy, out_valid} !== 3'b000)
         $display("FAIL empty_after: got %b want 000", {done, busy, out_valid});
      else n_pass++;
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL empty_queue: got %0d want 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_backpressure();
      beat_t o, e;
      out_ready = 1'b0;
      do_start(12'h003);
      for (int k = 0; k < 3; k++) begin
         o = obs_beat();
         e = exp_q[0];
         n_checks++;
         if (!out_valid || o !== e)
            $display("FAIL stall_hold%0d: got v=%b %h want v=1 %h", k, out_valid, o, e);
         else n_pass++;
         if (k == 2) out_ready = 1'b1;
         @(negedge clk);
      end
      void'(exp_q.pop_front());
      o = obs_beat();
      e = exp_q.pop_front();
      n_checks++;
      if (!out_valid || o !== e) $display("FAIL stall_final: got v=%b %h want v=1 %h", out_valid, o, e);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 2'b10) $display("FAIL stall_done: got %b want 10", {done, busy});
      else n_pass++;
   endtask

   task automatic test_start_ignored();
      beat_t o, e;
      out_ready = 1'b1;
      do_start(12'h00C);
      start = 1'b1;
      req   = 12'h800;
      for (int k = 0; k < 2; k++) begin
         o = obs_beat();
         e = exp_q.pop_front();
         n_checks++;
         if (!out_valid || o !== e) $display("FAIL busy_start_beat%0d: got v=%b %h want v=1 %h", k, out_valid, o, e);
         else n_pass++;
         @(negedge clk);
      end
      start = 1'b0;
      req   = '0;
      n_checks++;
      if ({done, busy, out_valid} !== 3'b100)
         $display("FAIL busy_start_done: got %b want 100", {done, busy, out_valid});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({done, busy, out_valid} !== 3'b000)
         $display("FAIL busy_start_idle: got %b want 000", {done, busy, out_valid});
      else n_pass++;
   endtask

   task automatic test_reset_mid_scan();
      beat_t o, e;
      logic [15:0] obs;
      out_ready = 1'b1;
      do_start(12'hFFF);
      for (int k = 0; k < 2; k++) begin
         o = obs_beat();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL rst_scan_beat%0d: got %h want %h", k, o, e);
         else n_pass++;
         if (k == 1) reset = 1'b1;
         else @(negedge clk);
      end
      exp_q.delete();
      @(negedge clk);
      obs = {busy, out_valid, done, first, second, count, last};
      n_checks++;
      if (obs !== 16'h0) $display("FAIL rst_scan_outputs: got %h want 0000", obs);
      else n_pass++;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 2'b00) $display("FAIL rst_scan_no_done: got %b want 00", {done, busy});
      else n_pass++;
      do_start(12'h001);
      o = obs_beat();
      e = exp_q.pop_front();
      n_checks++;
      if (!out_valid || o !== e) $display("FAIL rst_restart_beat: got v=%b %h want v=1 %h", out_valid, o, e);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 2'b10) $display("FAIL rst_restart_done: got %b want 10", {done, busy});
      else n_pass++;
   endtask

   task automatic test_full_throughput();
      beat_t o, e;
      out_ready = 1'b1;
      do_start(12'hFFF);
      for (int i = 0; i < 12; i++) begin
         o = obs_beat();
         n_checks++;
         if (!out_valid || exp_q.size() == 0) begin
            $display("FAIL full_bubble%0d: got v=%b q=%0d want v=1", i, out_valid, exp_q.size());
         end else begin
            e = exp_q.pop_front();
            if (o !== e || first !== CW'(12 - i))
               $display("FAIL full_beat%0d: got %h want %h", i, o, e);
            else n_pass++;
         end
         @(negedge clk);
      end
      n_checks++;
      if ({done, busy} !== 2'b10) $display("FAIL full_done: got %b want 10", {done, busy});
      else n_pass++;
      exp_q.delete();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset = 1'b1; start = 1'b0; req = '0; out_ready = 1'b0;
      test_reset();
      test_mixed();
      test_empty();
      test_backpressure();
      test_start_ignored();
      test_reset_mid_scan();
      test_full_throughput();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/priority_scan_encoder.md
PRIORITY_SCAN_ENCODER -- requirements
Module: priority_scan_encoder

Interface
REQ-001 Parameter N, default 12, meaning request vector width (N >= 2).
REQ-002 Derived constant CW = clog2(N+1), meaning code width (4 for N=12).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  load request: snapshot req when idle.
REQ-006 req  input  N  request vector; bit i has priority i (bit N-1 highest).
REQ-007 busy  output  1  high while a snapshot is being scanned.
REQ-008 out_valid  output  1  first/second/last/count are valid.
REQ-009 out_ready  input  1  consumer accepts the current first code.
REQ-010 first  output  CW  code of the highest remaining request.
REQ-011 second  output  CW  code of the second-highest remaining request.
REQ-012 last  output  1  current beat is the final one (one request remaining).
REQ-013 count  output  CW  number of requests remaining in the snapshot.
REQ-014 done  output  1  one-cycle pulse on scan completion.

Function
REQ-015 Code mapping SHALL be: bit i -> code i+1; no request -> code 0.
REQ-016 States SHALL be IDLE and SCAN; a snapshot register (N bits) holds the remaining requests.
REQ-017 In IDLE, start=1 with req!=0 SHALL load the snapshot and enter SCAN; out_valid is high on the next cycle (latency 1).
REQ-018 In IDLE, start=1 with req==0 SHALL leave the block in IDLE and pulse done on the next cycle, with out_valid held low.
REQ-019 In SCAN, busy=1 and out_valid=1 SHALL hold continuously until the final handshake.
REQ-020 first and second SHALL be the codes of the highest and second-highest set bits of the snapshot; second=0 when only one bit remains.
REQ-021 count SHALL equal the popcount of the snapshot; last SHALL equal (count==1).
REQ-022 A handshake (out_valid and out_ready) SHALL clear the highest set snapshot bit at that edge; the next beat appears on the following cycle.
REQ-023 With out_ready held high, the block SHALL sustain one code per cycle.
REQ-024 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-025 A handshake with last=1 SHALL return the block to IDLE and pulse done for exactly one cycle after that edge.
REQ-026 start SHALL be ignored while busy; a start in the same cycle as the final handshake is also ignored.
REQ-027 In IDLE, first, second, count and last SHALL all be 0.

Reset
REQ-028 While reset=1, the block SHALL enter IDLE at the next edge, clear the snapshot, and drive busy, out_valid, done, first, second, count and last to 0.
REQ-029 Reset SHALL take precedence over start and handshakes; a reset during SCAN abandons the scan without a done pulse.

Structure
REQ-030 The state enumeration and the code-width function clog2 SHALL reside in a shared package, prio_pkg.
REQ-031 A combinational sub-module prio_enc_n (N-bit highest-set-bit to code) SHALL be instantiated twice:
  - on the snapshot, producing first;
  - on the snapshot with its highest bit masked, producing second.
REQ-032 RTL SHALL be single-clock and synthesizable, with no latches (all combinational outputs fully assigned).

Verification (N=12)
REQ-033 Mixed requests, no stall:
  - stimulus: start with req=12'b1000_0010_0001, out_ready=1.
  - response: beats (first, second, count) = (12,6,3), (6,1,2), (1,0,1); last on beat 3; done pulse next cycle.
REQ-034 Empty request:
  - stimulus: start with req=0.
  - response: no out_valid; done pulse one cycle later; busy stays 0.
REQ-035 Backpressure:
  - stimulus: req=12'h003, out_ready=0 for 3 cycles, then 1.
  - response: first=2, second=1, count=2 held stable for 3 cycles; then first=1, second=0, last=1.
REQ-036 Start ignored while busy:
  - stimulus: start with req=12'h800 mid-scan of req=12'h00C.
  - response: codes 4, then 3 only; the new request is ignored.
REQ-037 Reset mid-scan:
  - stimulus: reset after the first handshake of req=12'hFFF.
  - response: all outputs 0 next cycle; no done pulse; a new start works normally.
REQ-038 Full vector throughput:
  - stimulus: req=12'hFFF, out_ready=1.
  - response: 12 consecutive beats with first = 12 down to 1; count = 12 down to 1.
